// File: rtl/rst_clk_ctrl_if.sv
// Signal bundle between the reset/clock-enable sequencer and its surroundings.
// The master side is the sequencer; the slave side supplies lock/button and observes the CPU controls.
interface rst_clk_ctrl_if;
  logic       clk_lock;
  logic       btn_rst;
  logic       cpu_rst_n;
  logic       cpu_clk_en;
  logic [1:0] rst_cause;
  logic [1:0] state_o;

  modport master (
    input  clk_lock,
    input  btn_rst,
    output cpu_rst_n,
    output cpu_clk_en,
    output rst_cause,
    output state_o
  );

  modport slave (
    output clk_lock,
    output btn_rst,
    input  cpu_rst_n,
    input  cpu_clk_en,
    input  rst_cause,
    input  state_o
  );
endinterface

// File: rtl/rst_clk_ctrl.sv
// Reset/clock-enable sequencer: synchronizes PLL lock and the reset button, debounces the button,
// and walks the CPU through WAIT_LOCK -> STABLE -> HOLD -> RUN with a registered reset and clock enable.
module rst_clk_ctrl #(
  parameter int DEBOUNCE_CYCLES    = 50000,
  parameter int LOCK_STABLE_CYCLES = 256,
  parameter int RST_HOLD_CYCLES    = 16
) (
  input  logic           clk,
  input  logic           rst,
  rst_clk_ctrl_if.master bus
);

  localparam int MAX_LS = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ? LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
  localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > MAX_LS) ? DEBOUNCE_CYCLES : MAX_LS;
  localparam int CW = $clog2(MAX_CYCLES);

  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD_CYCLES - 1);

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_LOCK = 2'b01;
  localparam logic [1:0] CAUSE_BTN  = 2'b10;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_e;

  logic          lock_meta_q, lock_meta_d;
  logic          lock_s_q,    lock_s_d;
  logic          btn_meta_q,  btn_meta_d;
  logic          btn_s_q,     btn_s_d;
  logic          btn_db_q,    btn_db_d;
  logic [CW-1:0] cnt_db_q,    cnt_db_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  state_e        state_q,     state_d;
  logic [1:0]    cause_q,     cause_d;
  logic          cpu_rst_n_q, cpu_rst_n_d;
  logic          cpu_clk_en_q, cpu_clk_en_d;

  // Synchronizer shift and debounce: btn_db only follows btn_s after a full run of mismatches.
  always_comb begin
    lock_meta_d = bus.clk_lock;
    lock_s_d    = lock_meta_q;
    btn_meta_d  = bus.btn_rst;
    btn_s_d     = btn_meta_q;
    btn_db_d    = btn_db_q;
    cnt_db_d    = '0;
    if (btn_s_q != btn_db_q) begin
      if (cnt_db_q == DB_LAST) begin
        btn_db_d = btn_s_q;
        cnt_db_d = '0;
      end else begin
        cnt_db_d = cnt_db_q + 1'b1;
      end
    end else begin
      cnt_db_d = '0;
    end
  end

  // Sequencer next state; lock loss outranks the button in every state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cause_d      = cause_q;
    cpu_rst_n_d  = 1'b0;
    cpu_clk_en_d = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s_q) begin
          state_d = STABLE;
        end else begin
          state_d = WAIT_LOCK;
        end
      end
      STABLE: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (btn_db_q) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          cause_d = CAUSE_LOCK;
        end else if (btn_db_q) begin
          state_d = HOLD;
          cnt_d   = '0;
          cause_d = CAUSE_BTN;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
    // Outputs decode the next state so they switch on the same edge as state_o.
    cpu_rst_n_d  = (state_d == RUN);
    cpu_clk_en_d = (state_d == HOLD) || (state_d == RUN);
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_meta_q  <= 1'b0;
      lock_s_q     <= 1'b0;
      btn_meta_q   <= 1'b0;
      btn_s_q      <= 1'b0;
      btn_db_q     <= 1'b0;
      cnt_db_q     <= '0;
      cnt_q        <= '0;
      state_q      <= WAIT_LOCK;
      cause_q      <= CAUSE_POR;
      cpu_rst_n_q  <= 1'b0;
      cpu_clk_en_q <= 1'b0;
    end else begin
      lock_meta_q  <= lock_meta_d;
      lock_s_q     <= lock_s_d;
      btn_meta_q   <= btn_meta_d;
      btn_s_q      <= btn_s_d;
      btn_db_q     <= btn_db_d;
      cnt_db_q     <= cnt_db_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      cause_q      <= cause_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      cpu_clk_en_q <= cpu_clk_en_d;
    end
  end

  assign bus.cpu_rst_n  = cpu_rst_n_q;
  assign bus.cpu_clk_en = cpu_clk_en_q;
  assign bus.rst_cause  = cause_q;
  assign bus.state_o    = state_q;

endmodule
